// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register.
// Captures the MEM-stage result, destination and write-back controls each clock.
// A MEM-stage freeze, or an input bubble, turns into a bubble at WB so that
// write-back never repeats and never commits an unfinished load/store.
// Optional feature macro: MEM_WB_PERF_EN adds saturating stall/retire counters.
module mem_wb_reg #(
    parameter int DEST_W = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              valid_in,
    input  logic              WB_en_in,
    input  logic              MEMread_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] MEM_result_in,
    output logic              valid,
    output logic              WB_en,
    output logic              MEMread,
    output logic [DEST_W-1:0] dest,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] MEM_result,
    output logic [DATA_W-1:0] WB_value
`ifdef MEM_WB_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  retired
`endif
);

    logic              valid_q,   valid_d;
    logic              wb_en_q,   wb_en_d;
    logic              memread_q, memread_d;
    logic [DEST_W-1:0] dest_q,    dest_d;
    logic [DATA_W-1:0] alu_q,     alu_d;
    logic [DATA_W-1:0] mem_q,     mem_d;

    // Next state: a frozen or empty slot becomes a bubble; data fields only move when not frozen
    always_comb begin
        valid_d   = 1'b0;
        wb_en_d   = 1'b0;
        memread_d = 1'b0;
        dest_d    = dest_q;
        alu_d     = alu_q;
        mem_d     = mem_q;
        if (!freeze) begin
            valid_d   = valid_in;
            wb_en_d   = valid_in & WB_en_in;
            memread_d = valid_in & MEMread_in;
            dest_d    = dest_in;
            alu_d     = ALU_result_in;
            mem_d     = MEM_result_in;
        end
    end

    // Pipeline register with asynchronous clear of every field
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            memread_q <= 1'b0;
            dest_q    <= '0;
            alu_q     <= '0;
            mem_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            wb_en_q   <= wb_en_d;
            memread_q <= memread_d;
            dest_q    <= dest_d;
            alu_q     <= alu_d;
            mem_q     <= mem_d;
        end
    end

    // Registered outputs and the zero-latency write-back value select
    always_comb begin
        valid      = valid_q;
        WB_en      = wb_en_q;
        MEMread    = memread_q;
        dest       = dest_q;
        ALU_result = alu_q;
        MEM_result = mem_q;
        WB_value   = memread_q ? mem_q : alu_q;
    end

`ifdef MEM_WB_PERF_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] ret_q,   ret_d;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Counter next state: freeze counts a stall, an accepted real instruction counts a retire
    always_comb begin
        stall_d = stall_q;
        ret_d   = ret_q;
        if (freeze) begin
            stall_d = sat_inc(stall_q);
        end else if (valid_in) begin
            ret_d = sat_inc(ret_q);
        end
    end

    // Counter registers, cleared with the pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            ret_q   <= '0;
        end else begin
            stall_q <= stall_d;
            ret_q   <= ret_d;
        end
    end

    assign stall_cycles = stall_q;
    assign retired      = ret_q;
`else
    // Counter width is only meaningful with the counters present
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
module tb_mem_wb_reg;

    localparam int DEST_W = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int VEC_W  = 3 + DEST_W + 3 * DATA_W;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              freeze;
    logic              valid_in;
    logic              WB_en_in;
    logic              MEMread_in;
    logic [DEST_W-1:0] dest_in;
    logic [DATA_W-1:0] ALU_result_in;
    logic [DATA_W-1:0] MEM_result_in;
    logic              valid;
    logic              WB_en;
    logic              MEMread;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] ALU_result;
    logic [DATA_W-1:0] MEM_result;
    logic [DATA_W-1:0] WB_value;
`ifdef MEM_WB_PERF_EN
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  retired;
`endif

    int vectors = 0;
    int errors  = 0;

    // Reference state: what the WB stage should currently see
    logic              m_valid, m_wb, m_mr;
    logic [DEST_W-1:0] m_dest;
    logic [DATA_W-1:0] m_alu, m_mem;
    int                m_stall, m_ret;

    logic [VEC_W-1:0] obs;
    assign obs = {valid, WB_en, MEMread, dest, ALU_result, MEM_result, WB_value};

    mem_wb_reg #(.DEST_W(DEST_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .valid_in      (valid_in),
        .WB_en_in      (WB_en_in),
        .MEMread_in    (MEMread_in),
        .dest_in       (dest_in),
        .ALU_result_in (ALU_result_in),
        .MEM_result_in (MEM_result_in),
        .valid         (valid),
        .WB_en         (WB_en),
        .MEMread       (MEMread),
        .dest          (dest),
        .ALU_result    (ALU_result),
        .MEM_result    (MEM_result),
        .WB_value      (WB_value)
`ifdef MEM_WB_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .retired       (retired)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [VEC_W-1:0] exp_vec();
        return {m_valid, m_wb, m_mr, m_dest, m_alu, m_mem, (m_mr ? m_mem : m_alu)};
    endfunction

    task automatic model_clear();
        m_valid = 0; m_wb = 0; m_mr = 0; m_dest = '0; m_alu = '0; m_mem = '0;
        m_stall = 0; m_ret = 0;
    endtask

    // Apply one cycle of inputs (called at a negedge), advance the reference, return at next negedge
    task automatic drive_cycle(input logic f, input logic vi, input logic we, input logic mr,
                               input logic [DEST_W-1:0] d, input logic [DATA_W-1:0] a,
                               input logic [DATA_W-1:0] m);
        freeze = f; valid_in = vi; WB_en_in = we; MEMread_in = mr;
        dest_in = d; ALU_result_in = a; MEM_result_in = m;
        @(posedge clk);
        if (rst) begin
            if (f) begin
                m_valid = 0; m_wb = 0; m_mr = 0;
                m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            end else begin
                m_valid = vi; m_wb = vi & we; m_mr = vi & mr;
                m_dest = d; m_alu = a; m_mem = m;
                if (vi) m_ret = (m_ret < CMAX) ? m_ret + 1 : CMAX;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        freeze = 0; valid_in = 1; WB_en_in = 1; MEMread_in = 1;
        dest_in = 4'hA; ALU_result_in = 32'h1111_2222; MEM_result_in = 32'h3333_4444;
        rst = 0;
        model_clear();
        @(negedge clk);
        vectors++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_clear: got %h expected 0", obs);
        end
`ifdef MEM_WB_PERF_EN
        vectors++;
        if (stall_cycles !== '0 || retired !== '0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, retired);
        end
`endif
        rst = 1;
        drive_cycle(0, 1, 1, 0, 4'h3, 32'hCAFE_0001, 32'h0BAD_0002);
        vectors++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release_load: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_alu_write();
        drive_cycle(0, 1, 1, 0, 4'd5, 32'h0000_1234, 32'h5555_AAAA);
        vectors++;
        if (valid !== 1'b1 || WB_en !== 1'b1 || dest !== 4'd5 || WB_value !== 32'h1234) begin
            errors++;
            $display("FAIL alu_write: got v=%b we=%b d=%0d wbv=%h expected 1 1 5 00001234",
                     valid, WB_en, dest, WB_value);
        end
        vectors++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL alu_write_vec: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_load_freeze();
        int s0, r0, commits;
        commits = 0;
`ifdef MEM_WB_PERF_EN
        s0 = int'(stall_cycles); r0 = int'(retired);
`else
        s0 = 0; r0 = 0;
`endif
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, 1, 1, 1, 4'd7, 32'h0000_0100, 32'hFFFF_0000 + i);
            vectors++;
            if (valid !== 1'b0 || WB_en !== 1'b0 || obs !== exp_vec()) begin
                errors++;
                $display("FAIL load_freeze_bubble%0d: got %h expected %h", i, obs, exp_vec());
            end
            if (valid === 1'b1) commits++;
        end
        drive_cycle(0, 1, 1, 1, 4'd7, 32'h0000_0100, 32'hDEAD_BEEF);
        vectors++;
        if (valid !== 1'b1 || WB_en !== 1'b1 || dest !== 4'd7 || WB_value !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_commit: got v=%b we=%b d=%0d wbv=%h expected 1 1 7 deadbeef",
                     valid, WB_en, dest, WB_value);
        end
        if (valid === 1'b1) commits++;
        drive_cycle(0, 0, 0, 0, 4'd0, 32'h0, 32'h0);
        if (valid === 1'b1) commits++;
        vectors++;
        if (commits != 1) begin
            errors++;
            $display("FAIL load_single_commit: got %0d commits expected 1", commits);
        end
`ifdef MEM_WB_PERF_EN
        vectors++;
        if (int'(stall_cycles) != s0 + 3 || int'(retired) != r0 + 1) begin
            errors++;
            $display("FAIL load_counters: got %0d/%0d expected %0d/%0d",
                     stall_cycles, retired, s0 + 3, r0 + 1);
        end
`endif
    endtask

    task automatic test_input_bubble();
        int r0;
`ifdef MEM_WB_PERF_EN
        r0 = int'(retired);
`else
        r0 = 0;
`endif
        drive_cycle(0, 0, 1, 1, 4'd9, 32'h0000_ABCD, 32'h0000_EF01);
        vectors++;
        if (WB_en !== 1'b0 || valid !== 1'b0 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL input_bubble: got %h expected %h", obs, exp_vec());
        end
`ifdef MEM_WB_PERF_EN
        vectors++;
        if (int'(retired) != r0) begin
            errors++;
            $display("FAIL bubble_retired: got %0d expected %0d", retired, r0);
        end
`endif
    endtask

    task automatic test_async_reset();
        drive_cycle(0, 1, 1, 0, 4'd2, 32'h7777_8888, 32'h9999_0000);
        drive_cycle(1, 1, 1, 1, 4'd4, 32'h1, 32'h2);
        freeze = 1;
        #2;
        rst = 0;
        model_clear();
        #1;
        vectors++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL async_reset_clear: got %h expected 0", obs);
        end
`ifdef MEM_WB_PERF_EN
        vectors++;
        if (stall_cycles !== '0 || retired !== '0) begin
            errors++;
            $display("FAIL async_reset_counters: got %0d/%0d expected 0/0", stall_cycles, retired);
        end
`endif
        @(negedge clk);
        rst = 1;
        drive_cycle(0, 1, 0, 1, 4'd6, 32'h0000_0010, 32'h0000_0020);
        vectors++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL after_async_reset: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1, 1, 1, 0, 4'(i), 32'(i), 32'(i));
        end
        vectors++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL saturation_hold: got %h expected %h", obs, exp_vec());
        end
`ifdef MEM_WB_PERF_EN
        vectors++;
        if (stall_cycles !== 4'd15) begin
            errors++;
            $display("FAIL stall_saturate: got %0d expected 15", stall_cycles);
        end
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            drive_cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
                        1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom);
            vectors++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random_%0d: got %h expected %h", i, obs, exp_vec());
            end
`ifdef MEM_WB_PERF_EN
            vectors++;
            if (int'(stall_cycles) != m_stall || int'(retired) != m_ret) begin
                errors++;
                $display("FAIL random_cnt_%0d: got %0d/%0d expected %0d/%0d",
                         i, stall_cycles, retired, m_stall, m_ret);
            end
`endif
        end
    endtask

    initial begin
        rst = 0;
        freeze = 0; valid_in = 0; WB_en_in = 0; MEMread_in = 0;
        dest_in = '0; ALU_result_in = '0; MEM_result_in = '0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_alu_write();
        test_load_freeze();
        test_input_bubble();
        test_async_reset();
        test_saturation();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
